// File: rtl/im_pipe_pkg.sv
// Shared widths and bundle layout for the input-matrix pipeline buffer.
// The bundle travels as one packed word so slices never split its fields.
package im_pipe_pkg;

  localparam int IM_DATA_W  = 32;
  localparam int IM_SHAMT_W = 5;
  localparam int IM_COL_W   = 2;
  localparam int IM_DST_W   = 4;

  typedef struct packed {
    logic [IM_DATA_W-1:0]  data;
    logic                  start_calc;
    logic                  load;
    logic [IM_SHAMT_W-1:0] shamt;
    logic [IM_COL_W-1:0]   col;
    logic [IM_DST_W-1:0]   odst;
  } im_bundle_t;

  // Flat width of a bundle for arbitrary field widths (two 1-bit flags included).
  function automatic int bundle_w(input int data_w, input int shamt_w,
                                  input int col_w, input int dst_w);
    return data_w + shamt_w + col_w + dst_w + 2;
  endfunction

endpackage

// File: rtl/im_pipe_slice.sv
// One elastic register slice: valid bit plus bundle register, 1-cycle latency.
// Accepts when empty or when downstream accepts; holds data under stall, flush clears valid only.
module im_pipe_slice
  import im_pipe_pkg::*;
#(
  parameter int BW = bundle_w(IM_DATA_W, IM_SHAMT_W, IM_COL_W, IM_DST_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          up_vld,
  input  logic [BW-1:0] up_dat,
  input  logic          rdy_in,
  output logic          rdy_out,
  output logic          vld,
  output logic [BW-1:0] dat
);

  logic          vld_q, vld_d;
  logic [BW-1:0] dat_q, dat_d;

  assign rdy_out = ~vld_q | rdy_in;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (rdy_out) begin
      vld_d = up_vld;
      // Bubbles advance the valid bit but leave the payload untouched.
      if (up_vld) dat_d = up_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld = vld_q;
  assign dat = dat_q;

endmodule

// File: rtl/im_pipe_buffer.sv
// Elastic IM bundle pipeline of STAGES slices; latency STAGES cycles, 1 bundle/cycle.
// Ready ripples combinationally from OREADY back to IREADY; FLUSH blocks both ends and empties all slices.
module im_pipe_buffer
  import im_pipe_pkg::*;
#(
  parameter int DATA_W  = IM_DATA_W,
  parameter int SHAMT_W = IM_SHAMT_W,
  parameter int COL_W   = IM_COL_W,
  parameter int DST_W   = IM_DST_W,
  parameter int STAGES  = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         IVALID,
  output logic                         IREADY,
  input  logic [DATA_W-1:0]            IDATA,
  input  logic                         ISTART_CALC,
  input  logic                         ILOAD,
  input  logic [SHAMT_W-1:0]           ISHAMT,
  input  logic [COL_W-1:0]             ICOL,
  input  logic [DST_W-1:0]             IODST,
  input  logic                         FLUSH,
  output logic                         OVALID,
  input  logic                         OREADY,
  output logic [DATA_W-1:0]            ODATA,
  output logic                         OSTART_CALC,
  output logic                         OLOAD,
  output logic [SHAMT_W-1:0]           OSHAMT,
  output logic [COL_W-1:0]             OCOL,
  output logic [DST_W-1:0]             OODST,
  output logic [$clog2(STAGES+1)-1:0]  OCC
);

  localparam int BW    = bundle_w(DATA_W, SHAMT_W, COL_W, DST_W);
  localparam int OCC_W = $clog2(STAGES+1);

  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] vld;
  logic [BW-1:0]     dat [STAGES];
  logic [BW-1:0]     in_dat;
  logic [OCC_W-1:0]  occ;

  assign in_dat      = {IDATA, ISTART_CALC, ILOAD, ISHAMT, ICOL, IODST};
  assign rdy[STAGES] = OREADY;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_slice
      logic          up_vld;
      logic [BW-1:0] up_dat;
      if (k == 0) begin : g_head
        assign up_vld = IVALID;
        assign up_dat = in_dat;
      end else begin : g_body
        assign up_vld = vld[k-1];
        assign up_dat = dat[k-1];
      end
      im_pipe_slice #(.BW(BW)) u_slice (
        .clk     (CLK),
        .rst     (RST),
        .flush   (FLUSH),
        .up_vld  (up_vld),
        .up_dat  (up_dat),
        .rdy_in  (rdy[k+1]),
        .rdy_out (rdy[k]),
        .vld     (vld[k]),
        .dat     (dat[k])
      );
    end
  endgenerate

  assign IREADY = rdy[0] & ~FLUSH;
  assign OVALID = vld[STAGES-1] & ~FLUSH;
  assign {ODATA, OSTART_CALC, OLOAD, OSHAMT, OCOL, OODST} = dat[STAGES-1];

  always_comb begin
    occ = '0;
    for (int i = 0; i < STAGES; i++) occ = occ + OCC_W'(vld[i]);
  end

  assign OCC = occ;

endmodule

// File: tb/tb_im_pipe_buffer.sv
// Directed bench: a cycle table on a 2-slice buffer plus reset and 3-slice field sequences.
module tb_im_pipe_buffer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IVALID, ISTART_CALC, ILOAD, FLUSH, OREADY;
  logic [31:0] IDATA;
  logic [4:0]  ISHAMT;
  logic [1:0]  ICOL;
  logic [3:0]  IODST;

  logic        IREADY, OVALID, OSTART_CALC, OLOAD;
  logic [31:0] ODATA;
  logic [4:0]  OSHAMT;
  logic [1:0]  OCOL;
  logic [3:0]  OODST;
  logic [1:0]  OCC;

  logic        ir3, ov3, osc3, old3;
  logic [31:0] od3;
  logic [4:0]  osh3;
  logic [1:0]  ocol3;
  logic [3:0]  odst3;
  logic [1:0]  occ3;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 CLK = ~CLK;

  im_pipe_buffer #(.STAGES(2)) dut (
    .CLK(CLK), .RST(RST), .IVALID(IVALID), .IREADY(IREADY), .IDATA(IDATA),
    .ISTART_CALC(ISTART_CALC), .ILOAD(ILOAD), .ISHAMT(ISHAMT), .ICOL(ICOL),
    .IODST(IODST), .FLUSH(FLUSH), .OVALID(OVALID), .OREADY(OREADY),
    .ODATA(ODATA), .OSTART_CALC(OSTART_CALC), .OLOAD(OLOAD), .OSHAMT(OSHAMT),
    .OCOL(OCOL), .OODST(OODST), .OCC(OCC)
  );

  im_pipe_buffer #(.STAGES(3)) dut3 (
    .CLK(CLK), .RST(RST), .IVALID(IVALID), .IREADY(ir3), .IDATA(IDATA),
    .ISTART_CALC(ISTART_CALC), .ILOAD(ILOAD), .ISHAMT(ISHAMT), .ICOL(ICOL),
    .IODST(IODST), .FLUSH(FLUSH), .OVALID(ov3), .OREADY(OREADY),
    .ODATA(od3), .OSTART_CALC(osc3), .OLOAD(old3), .OSHAMT(osh3),
    .OCOL(ocol3), .OODST(odst3), .OCC(occ3)
  );

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic [1:0]  e_occ;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic ordy,
                              input logic fl, input logic e_ir, input logic e_ov,
                              input logic [31:0] e_od, input logic [1:0] e_occ);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  initial begin
    // Each row: inputs held for one cycle; expected outputs are observed before the edge.
    // Streaming 1..8 with OREADY high
    vt.push_back(mk(1, 32'h1, 1, 0, 1, 0, 32'h0, 2'd0));
    vt.push_back(mk(1, 32'h2, 1, 0, 1, 0, 32'h0, 2'd1));
    for (int i = 3; i <= 8; i++)
      vt.push_back(mk(1, 32'(i), 1, 0, 1, 1, 32'(i - 2), 2'd2));
    vt.push_back(mk(0, 32'h0, 1, 0, 1, 1, 32'h7, 2'd2));
    vt.push_back(mk(0, 32'h0, 1, 0, 1, 1, 32'h8, 2'd1));
    vt.push_back(mk(0, 32'h0, 1, 0, 1, 0, 32'h8, 2'd0));
    // Backpressure fill, then stall with 0xA1 held
    vt.push_back(mk(1, 32'hA1, 0, 0, 1, 0, 32'h8, 2'd0));
    vt.push_back(mk(1, 32'hA2, 0, 0, 1, 0, 32'h8, 2'd1));
    vt.push_back(mk(1, 32'hA3, 0, 0, 0, 1, 32'hA1, 2'd2));
    vt.push_back(mk(1, 32'hA3, 0, 0, 0, 1, 32'hA1, 2'd2));
    // Full with simultaneous push/pop
    vt.push_back(mk(1, 32'hB3, 1, 0, 1, 1, 32'hA1, 2'd2));
    vt.push_back(mk(0, 32'h0, 1, 0, 1, 1, 32'hA2, 2'd2));
    vt.push_back(mk(1, 32'hD4, 0, 0, 1, 1, 32'hB3, 2'd1));
    // Flush while full with a pending input
    vt.push_back(mk(1, 32'hC0, 1, 1, 0, 0, 32'hB3, 2'd2));
    vt.push_back(mk(0, 32'h0, 1, 0, 1, 0, 32'hB3, 2'd0));
    vt.push_back(mk(0, 32'h0, 1, 0, 1, 0, 32'hB3, 2'd0));

    RST = 1'b1; IVALID = 0; IDATA = '0; ISTART_CALC = 0; ILOAD = 0;
    ISHAMT = '0; ICOL = '0; IODST = '0; FLUSH = 0; OREADY = 0;
    #3;
    chk("rst_ovalid", 64'(OVALID), 64'd0);
    chk("rst_occ", 64'(OCC), 64'd0);
    chk("rst_odata", 64'(ODATA), 64'd0);
    #9 RST = 1'b0;
    #1 chk("rst_iready", 64'(IREADY), 64'd1);

    foreach (vt[r]) begin
      IVALID = vt[r].iv; IDATA = vt[r].d; OREADY = vt[r].ordy; FLUSH = vt[r].fl;
      #1;
      chk($sformatf("row%0d_iready", r), 64'(IREADY), 64'(vt[r].e_ir));
      chk($sformatf("row%0d_ovalid", r), 64'(OVALID), 64'(vt[r].e_ov));
      chk($sformatf("row%0d_odata", r), 64'(ODATA), 64'(vt[r].e_od));
      chk($sformatf("row%0d_occ", r), 64'(OCC), 64'(vt[r].e_occ));
      @(posedge CLK); #1;
    end

    // Asynchronous reset with two bundles held
    FLUSH = 0; OREADY = 0; IVALID = 1; IDATA = 32'hE1;
    @(posedge CLK); #1 IDATA = 32'hE2;
    @(posedge CLK); #1 IVALID = 0;
    #1 chk("pre_rst_occ", 64'(OCC), 64'd2);
    chk("pre_rst_odata", 64'(ODATA), 64'hE1);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_ovalid", 64'(OVALID), 64'd0);
    chk("mid_rst_occ", 64'(OCC), 64'd0);
    chk("mid_rst_odata", 64'(ODATA), 64'd0);
    #2 RST = 1'b0;
    #1 chk("post_rst_iready", 64'(IREADY), 64'd1);

    // Field integrity through three slices
    @(posedge CLK); #1;
    OREADY = 1; IVALID = 1; IDATA = 32'h5A5A_1234;
    ISTART_CALC = 1; ILOAD = 0; ISHAMT = 5'd17; ICOL = 2'd2; IODST = 4'd9;
    #1 chk("s3_iready", 64'(ir3), 64'd1);
    @(posedge CLK); #1;
    IVALID = 0; IDATA = '0; ISTART_CALC = 0; ISHAMT = '0; ICOL = '0; IODST = '0;
    #1 chk("s3_ovalid_t1", 64'(ov3), 64'd0);
    @(posedge CLK); #1;
    chk("s3_ovalid_t2", 64'(ov3), 64'd0);
    @(posedge CLK); #1;
    chk("s3_ovalid_t3", 64'(ov3), 64'd1);
    chk("s3_odata", 64'(od3), 64'h5A5A_1234);
    chk("s3_start", 64'(osc3), 64'd1);
    chk("s3_load", 64'(old3), 64'd0);
    chk("s3_shamt", 64'(osh3), 64'd17);
    chk("s3_col", 64'(ocol3), 64'd2);
    chk("s3_odst", 64'(odst3), 64'd9);
    chk("s3_occ", 64'(occ3), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
